// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter onto one in-order data memory port; a tag FIFO routes responses back.
// Define DATA_MEM_ARB_FIXED_PRIO_EN to make port 0 always win instead of round-robin.
module data_mem_arbiter #(
  parameter int RS_ID_WIDTH     = 5,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  req_valid,
  output logic [1:0]                  req_ready,
  input  logic [1:0][RS_ID_WIDTH-1:0] req_rs_id,
  input  logic [1:0][4:0]             req_reg_addr,
  input  logic [1:0][31:0]            req_address,
  input  logic [1:0][3:0]             req_write_en,
  input  logic [1:0][31:0]            req_write_data,
  input  logic [1:0][3:0]             req_read_en,
  output logic [1:0]                  resp_valid,
  input  logic [1:0]                  resp_ready,
  output logic [RS_ID_WIDTH-1:0]      resp_rs_id,
  output logic [4:0]                  resp_reg_addr,
  output logic [31:0]                 resp_read_data,
  output logic                        mem_valid,
  input  logic                        mem_ready,
  output logic [31:0]                 mem_address,
  output logic [3:0]                  mem_write_en,
  output logic [31:0]                 mem_write_data,
  output logic [3:0]                  mem_read_en,
  input  logic                        mem_resp_valid,
  output logic                        mem_resp_ready,
  input  logic [31:0]                 mem_read_data
);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic                   port;
    logic [RS_ID_WIDTH-1:0] rs_id;
    logic [4:0]             reg_addr;
  } tag_t;

  tag_t          tags [MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          lock, lock_port;
  logic          pref, grant;
  logic          full, empty, push, pop;
  tag_t          head;

  assign full  = (count == CW'(MAX_OUTSTANDING));
  assign empty = (count == '0);
  assign head  = tags[rd_ptr];

`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
  assign pref = 1'b0;
`else
  logic rr_ptr;
  assign pref = rr_ptr;

  // rr_ptr names the port that wins the next tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rr_ptr <= 1'b0;
    else if (push) rr_ptr <= ~grant;
  end
`endif

  always_comb begin
    grant = 1'b0;
    if (lock)                    grant = lock_port;
    else if (req_valid == 2'b11) grant = pref;
    else                         grant = req_valid[1];
  end

  // Gating with rst keeps the memory request quiet for the whole reset pulse
  assign mem_valid      = ~rst & req_valid[grant] & ~full;
  assign mem_address    = req_address[grant];
  assign mem_write_en   = req_write_en[grant];
  assign mem_write_data = req_write_data[grant];
  assign mem_read_en    = req_read_en[grant];
  assign push           = mem_valid & mem_ready;

  always_comb begin
    req_ready = 2'b00;
    if (push) req_ready[grant] = 1'b1;
  end

  always_comb begin
    resp_valid = 2'b00;
    if (!empty) resp_valid[head.port] = mem_resp_valid;
  end

  assign mem_resp_ready = ~empty & resp_ready[head.port];
  assign pop            = mem_resp_ready & mem_resp_valid;
  assign resp_rs_id     = head.rs_id;
  assign resp_reg_addr  = head.reg_addr;
  assign resp_read_data = mem_read_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      lock      <= 1'b0;
      lock_port <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) tags[i] <= '0;
    end else begin
      lock <= mem_valid & ~mem_ready;
      if (mem_valid & ~mem_ready) lock_port <= grant;
      if (push) begin
        tags[wr_ptr] <= '{port: grant, rs_id: req_rs_id[grant], reg_addr: req_reg_addr[grant]};
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: per-cycle vector table plus hand-written lock, ordering and reset sequences.
module tb_data_mem_arbiter;
`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic            clk, rst;
  logic [1:0]      req_valid, req_ready;
  logic [1:0][4:0] req_rs_id, req_reg_addr;
  logic [1:0][31:0] req_address, req_write_data;
  logic [1:0][3:0] req_write_en, req_read_en;
  logic [1:0]      resp_valid, resp_ready;
  logic [4:0]      resp_rs_id, resp_reg_addr;
  logic [31:0]     resp_read_data;
  logic            mem_valid, mem_ready, mem_resp_valid, mem_resp_ready;
  logic [31:0]     mem_address, mem_write_data, mem_read_data;
  logic [3:0]      mem_write_en, mem_read_en;

  int checks = 0;
  int errors = 0;

  data_mem_arbiter #(.RS_ID_WIDTH(5), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rs_id(req_rs_id),
    .req_reg_addr(req_reg_addr), .req_address(req_address), .req_write_en(req_write_en),
    .req_write_data(req_write_data), .req_read_en(req_read_en),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rs_id(resp_rs_id),
    .resp_reg_addr(resp_reg_addr), .resp_read_data(resp_read_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_address(mem_address),
    .mem_write_en(mem_write_en), .mem_write_data(mem_write_data), .mem_read_en(mem_read_en),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_read_data(mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_before;
    logic [1:0]  rv;
    logic        mr;
    logic        mrv;
    logic [1:0]  rr;
    logic        emv;
    logic [1:0]  erq;
    logic [31:0] eaddr;
    logic [1:0]  erv;
    logic        emrr;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 2'b00; mem_ready = 1'b0; mem_resp_valid = 1'b0; resp_ready = 2'b00;
    mem_read_data = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    req_address[0] = 32'h100; req_address[1] = 32'h200;
    req_read_en[0] = 4'b1111; req_read_en[1] = 4'b0011;
    req_write_en = '0; req_write_data[0] = 32'hA0; req_write_data[1] = 32'hB1;
    req_rs_id = '0; req_reg_addr = '0;
    req_valid = 2'b11; mem_ready = 1'b1; mem_resp_valid = 1'b1; resp_ready = 2'b11;
    mem_read_data = 32'h0;

    // reset with busy inputs: all handshake outputs low
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mem_resp_ready", mem_resp_ready, 0);
    idle_inputs();
    tick();
    rst = 1'b0;

    // single load on port 0, answered next cycle
    req_valid = 2'b01; mem_ready = 1'b1; req_rs_id[0] = 5'd3; req_reg_addr[0] = 5'd7;
    @(negedge clk);
    chk("ld_mem_valid", mem_valid, 1);
    chk("ld_addr", mem_address, 32'h100);
    chk("ld_read_en", mem_read_en, 4'b1111);
    chk("ld_req_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00; mem_resp_valid = 1'b1; mem_read_data = 32'hDEADBEEF; resp_ready = 2'b11;
    @(negedge clk);
    chk("ld_resp_valid", resp_valid, 2'b01);
    chk("ld_rs_id", resp_rs_id, 5'd3);
    chk("ld_reg", resp_reg_addr, 5'd7);
    chk("ld_data", resp_read_data, 32'hDEADBEEF);
    chk("ld_mem_resp_ready", mem_resp_ready, 1);
    tick();
    idle_inputs();

    // per-cycle table: alternating grants (rows 0-3), fill to depth (rows 4-11)
    tbl[0] = '{1, 2'b11, 1, 1, 2'b11, 1, 2'b01, 32'h100, 2'b00, 0};
    tbl[1] = '{0, 2'b11, 1, 1, 2'b11, 1, FIXED ? 2'b01 : 2'b10, FIXED ? 32'h100 : 32'h200, 2'b01, 1};
    tbl[2] = '{0, 2'b11, 1, 1, 2'b11, 1, 2'b01, 32'h100, FIXED ? 2'b01 : 2'b10, 1};
    tbl[3] = '{0, 2'b11, 1, 1, 2'b11, 1, FIXED ? 2'b01 : 2'b10, FIXED ? 32'h100 : 32'h200, 2'b01, 1};
    tbl[4] = '{1, 2'b01, 1, 0, 2'b00, 1, 2'b01, 32'h100, 2'b00, 0};
    tbl[5] = '{0, 2'b01, 1, 0, 2'b00, 1, 2'b01, 32'h100, 2'b00, 0};
    tbl[6] = '{0, 2'b01, 1, 0, 2'b00, 1, 2'b01, 32'h100, 2'b00, 0};
    tbl[7] = '{0, 2'b01, 1, 0, 2'b00, 1, 2'b01, 32'h100, 2'b00, 0};
    tbl[8] = '{0, 2'b01, 1, 0, 2'b00, 0, 2'b00, 32'h100, 2'b00, 0};
    tbl[9] = '{0, 2'b01, 1, 1, 2'b01, 0, 2'b00, 32'h100, 2'b01, 1};
    tbl[10] = '{0, 2'b01, 1, 0, 2'b00, 1, 2'b01, 32'h100, 2'b00, 0};
    tbl[11] = '{0, 2'b01, 1, 0, 2'b00, 0, 2'b00, 32'h100, 2'b00, 0};
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].rst_before) do_reset();
      req_valid = tbl[i].rv; mem_ready = tbl[i].mr;
      mem_resp_valid = tbl[i].mrv; resp_ready = tbl[i].rr;
      @(negedge clk);
      chk($sformatf("v%0d_mem_valid", i), mem_valid, tbl[i].emv);
      chk($sformatf("v%0d_req_ready", i), req_ready, tbl[i].erq);
      if (tbl[i].emv) chk($sformatf("v%0d_addr", i), mem_address, tbl[i].eaddr);
      chk($sformatf("v%0d_resp_valid", i), resp_valid, tbl[i].erv);
      chk($sformatf("v%0d_mem_resp_ready", i), mem_resp_ready, tbl[i].emrr);
      tick();
    end

    // lock: port 1 stalled 3 cycles while port 0 also requests
    do_reset();
    req_valid = 2'b10; mem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("lk%0d_addr", c), mem_address, 32'h200);
      chk($sformatf("lk%0d_req_ready", c), req_ready, 2'b00);
      tick();
      req_valid = 2'b11;
    end
    mem_ready = 1'b1;
    @(negedge clk);
    chk("lk3_addr", mem_address, 32'h200);
    chk("lk3_req_ready", req_ready, 2'b10);
    tick();
    @(negedge clk);
    chk("lk4_addr", mem_address, 32'h100);
    chk("lk4_req_ready", req_ready, 2'b01);
    tick();
    // stall again so a lock is held with two tags outstanding
    mem_ready = 1'b0;
    tick();
    tick();
    #2;
    req_valid = 2'b11; mem_ready = 1'b1; mem_resp_valid = 1'b1; resp_ready = 2'b11;
    rst = 1'b1;
    #1;
    chk("arst_mem_valid", mem_valid, 0);
    chk("arst_req_ready", req_ready, 2'b00);
    chk("arst_resp_valid", resp_valid, 2'b00);
    chk("arst_mem_resp_ready", mem_resp_ready, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_mem_valid", mem_valid, 1);
    chk("post_rst_addr", mem_address, 32'h100);
    chk("post_rst_resp_valid", resp_valid, 2'b00);
    tick();

    // response ordering with port 1 back-pressure
    do_reset();
    mem_ready = 1'b1;
    req_valid = 2'b01; req_rs_id[0] = 5'd1; req_reg_addr[0] = 5'd9;
    @(negedge clk); chk("ord_iss0", req_ready, 2'b01); tick();
    req_valid = 2'b10; req_rs_id[1] = 5'd2; req_reg_addr[1] = 5'd10;
    @(negedge clk); chk("ord_iss1", req_ready, 2'b10); tick();
    req_valid = 2'b01; req_rs_id[0] = 5'd4; req_reg_addr[0] = 5'd12;
    @(negedge clk); chk("ord_iss2", req_ready, 2'b01); tick();
    req_valid = 2'b00; mem_resp_valid = 1'b1; resp_ready = 2'b01;
    @(negedge clk);
    chk("ord_r0_valid", resp_valid, 2'b01);
    chk("ord_r0_rs", resp_rs_id, 5'd1);
    chk("ord_r0_reg", resp_reg_addr, 5'd9);
    tick();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("ord_stall%0d_valid", c), resp_valid, 2'b10);
      chk($sformatf("ord_stall%0d_mrr", c), mem_resp_ready, 0);
      tick();
    end
    resp_ready = 2'b11;
    @(negedge clk);
    chk("ord_r1_valid", resp_valid, 2'b10);
    chk("ord_r1_rs", resp_rs_id, 5'd2);
    chk("ord_r1_mrr", mem_resp_ready, 1);
    tick();
    @(negedge clk);
    chk("ord_r2_valid", resp_valid, 2'b01);
    chk("ord_r2_rs", resp_rs_id, 5'd4);
    chk("ord_r2_reg", resp_reg_addr, 5'd12);
    tick();
    @(negedge clk);
    chk("ord_empty_valid", resp_valid, 2'b00);
    chk("ord_empty_mrr", mem_resp_ready, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
